serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single-bit line. Frame order is start bit, data LSB-first, optional parity, then stop bit(s). It is the transmit end of the team's single-bit serial link; its tx_dout feeds a D-flip-flop capture stage on the receive side. Bit period is a fixed number of clk cycles.

Parameters:
DATA_W, 8, payload width in bits (1..16)
CLKS_PER_BIT, 4, clk cycles per serial bit (>=1)
PARITY_EN, 1, 1 = parity bit after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_W  word to transmit, sampled only on acceptance
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
tx_dout  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: at any edge with rst=1: state IDLE, tx_dout=1, tx_busy=0, tx_done=0, tx_ready=0, counters cleared. tx_ready rises on the first cycle after rst deasserts. rst overrides all other inputs.
- Reset mid-frame: the frame is aborted. tx_dout=1 from the next edge. No tx_done is issued.
- Acceptance: occurs at a rising edge where tx_valid=1 and tx_ready=1 (edge E0). tx_data is latched into the shift register at E0. Later changes to tx_data have no effect on the frame.
- tx_ready=1 only in IDLE and outside reset. tx_valid asserted while busy is ignored; nothing is queued.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY_EN=0) -> STOP -> IDLE.
- START: begins the cycle after E0. tx_dout=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles.
- PARITY: bit = ^data for even parity, ~^data for odd parity; held CLKS_PER_BIT cycles.
- STOP: tx_dout=1 for STOP_BITS*CLKS_PER_BIT cycles.
- tx_busy=1 from the cycle after E0 through the last STOP cycle.
- Completion: the cycle after the last STOP cycle has state IDLE, tx_done=1 for exactly one cycle, and tx_ready=1.
- Frame length: F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles. tx_done is asserted in cycle F+1 after E0.
- Back-to-back: if tx_valid=1 in the tx_done cycle, that edge accepts the next word. Minimum word period is F+1 cycles, with the line high between frames.
- Bit timer: counts 0..CLKS_PER_BIT-1 and produces bit_end on the terminal count. The bit counter advances only on bit_end. CLKS_PER_BIT=1 must work (bit_end every cycle).
- Outputs are registered; tx_dout is glitch-free.
- Illegal parameters (CLKS_PER_BIT<1, STOP_BITS not 1/2) stop elaboration via a generate-time error.

Decomposition:
- Shared header serial_defs.vh holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit).
  - Idle line level constant.
  - Frame-length macro computing F from the parameters; reused by the future receiver and benches.
- One sub-module, serial_bit_timer (params CLKS_PER_BIT; ports clk, rst, run, bit_end), is instantiated once. It resets its count whenever run=0.

Test Plan:
1. Reset: rst=1 for 3 cycles with tx_valid=1 -> tx_dout=1, tx_ready=0, tx_busy=0, no frame; tx_ready=1 one cycle after release.
2. Send 0xA5 (defaults) -> line per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1; F=44; tx_done at cycle 45; tx_busy high for cycles 1..44.
3. Back-to-back with tx_valid held: 0x00 then 0xFF -> parity 0 and 0; second start bit begins at cycle 46. With PARITY_ODD=1 the parity bits are 1 and 1.
4. Change tx_data from 0x3C to 0xC3 during the DATA state -> serialized bits still 0,0,1,1,1,1,0,0.
5. Assert rst during data bit 3 -> tx_dout=1 next edge, no tx_done. New word 0x5A after release transmits a complete, correct frame.
6. Pulse tx_valid (0x11) while busy, plus CLKS_PER_BIT=1, STOP_BITS=2, PARITY_EN=0 config -> no extra frame; F=11 cycles; tx_done at cycle 12.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the single-bit serial link: FSM state encoding,
// idle line level and the frame-length helper used by transmitter and receiver.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Clock cycles from the first start-bit cycle through the last stop cycle.
    function automatic int unsigned frame_len(
        input int unsigned data_w,
        input int unsigned parity_en,
        input int unsigned stop_bits,
        input int unsigned clks_per_bit
    );
        return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// terminal count; the count is held at zero whenever run is low.
module serial_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;

    // With CLKS_PER_BIT=1 the terminal count is 0, so bit_end follows run.
    assign bit_end = run && (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !run || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional
// parity, stop bit(s); all outputs come straight from flops.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_dout,
    output logic              tx_busy,
    output logic              tx_done
);

    if (CLKS_PER_BIT < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        DATA_W < 1 || DATA_W > 16) begin : g_bad_params
        $error("serial_tx: illegal parameter combination");
    end

    localparam int unsigned CNT_W = $clog2(DATA_W + 2);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              parity, parity_n;
    logic              dout_n, busy_n, done_n, ready_n;
    logic              run, bit_end;

    assign run = (state != ST_IDLE);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .bit_end(bit_end)
    );

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        parity_n  = parity;
        done_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n   = ST_START;
                    shift_n   = tx_data;
                    parity_n  = (^tx_data) ^ (PARITY_ODD != 0);
                    bit_cnt_n = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = ST_IDLE;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so the line changes on the
    // same edge as the state register.
    always_comb begin
        dout_n = IDLE_LEVEL;
        case (state_n)
            ST_START:  dout_n = ~IDLE_LEVEL;
            ST_DATA:   dout_n = shift_n[0];
            ST_PARITY: dout_n = parity_n;
            default:   dout_n = IDLE_LEVEL;
        endcase
        busy_n  = (state_n != ST_IDLE);
        ready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            parity   <= 1'b0;
            tx_dout  <= IDLE_LEVEL;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            parity   <= parity_n;
            tx_dout  <= dout_n;
            tx_busy  <= busy_n;
            tx_done  <= done_n;
            tx_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: three configurations driven from vector
// tables, hand-written corner sequences and random words against a frame model.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       ready [3];
    logic       dout  [3];
    logic       busy  [3];
    logic       done  [3];

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          exp_q[$];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_dout(dout[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_dout(dout[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_dout(dout[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    function automatic int clks_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction
    function automatic bit par_en_of(input int k);
        return (k != 2);
    endfunction
    function automatic bit odd_of(input int k);
        return (k == 1);
    endfunction
    function automatic int stops_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected line level for every cycle of a frame, built slot by slot.
    task automatic build_expected(input int k, input logic [7:0] d);
        bit slots[$];
        int ones;
        slots = {};
        ones  = 0;
        slots.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            slots.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par_en_of(k))
            slots.push_back(odd_of(k) ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int s = 0; s < stops_of(k); s++) slots.push_back(1'b1);
        exp_q = {};
        foreach (slots[i]) repeat (clks_of(k)) exp_q.push_back(slots[i]);
    endtask

    // Called at a negedge with instance k idle; returns at the negedge of the done cycle.
    task automatic send(input int k, input logic [7:0] d, input bit keep,
                        input int change_at, input int pulse_at, input logic [7:0] alt,
                        output int done_at, output bit slot_seen);
        int f;
        int pidx;
        logic [3:0] exp;
        build_expected(k, d);
        f    = exp_q.size();
        pidx = 9 * clks_of(k) + 1;
        data[k]  = d;
        valid[k] = 1'b1;
        done_at   = 0;
        slot_seen = 1'b0;
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk);
            exp = (c <= f) ? {exp_q[c-1], 3'b100} : 4'b1011;
            chk($sformatf("u%0d_d%02h_cycle%0d", k, d, c),
                {dout[k], busy[k], done[k], ready[k]}, exp);
            if (done[k] === 1'b1 && done_at == 0) done_at = c;
            if (c == pidx) slot_seen = dout[k];
            if (c == 1 && !keep) valid[k] = 1'b0;
            if (c == change_at) data[k] = alt;
            if (c == pulse_at) valid[k] = 1'b1;
            else if (c == pulse_at + 1) valid[k] = 1'b0;
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d_idle", k), {dout[k], busy[k], done[k], ready[k]}, 4'b1001);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [7:0] alt;
        int         change_at;
        int         pulse_at;
        bit         slot;
        int         done_c;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         da;
        bit         ps;
        int         k;
        int         f;
        int         ch;
        int         pu;
        logic [7:0] d;
        logic [7:0] a;

        vecs[0] = '{0, 8'hA5, 8'h00, 0,  0, 1'b0, 45};
        vecs[1] = '{0, 8'h3C, 8'hC3, 10, 0, 1'b0, 45};
        vecs[2] = '{1, 8'hA5, 8'h00, 0,  0, 1'b1, 45};
        vecs[3] = '{2, 8'h3C, 8'h11, 5,  5, 1'b1, 12};
        vecs[4] = '{1, 8'h01, 8'h00, 0,  0, 1'b0, 45};
        vecs[5] = '{0, 8'h07, 8'h00, 0,  0, 1'b1, 45};

        // Reset held with valid asserted: nothing may start.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data[i]  = 8'hFF;
            valid[i] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("u%0d_in_reset", i), {dout[i], busy[i], done[i], ready[i]}, 4'b1000);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_after_release", i), {dout[i], busy[i], done[i], ready[i]}, 4'b1001);
            valid[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) idle(i, 1);

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].k, vecs[v].d, 1'b0, vecs[v].change_at, vecs[v].pulse_at,
                 vecs[v].alt, da, ps);
            chk($sformatf("vec%0d_done_cycle", v), da, vecs[v].done_c);
            chk($sformatf("vec%0d_slot_after_data", v), ps, vecs[v].slot);
            idle(vecs[v].k, 3);
        end

        // Back-to-back with valid held through the first frame.
        for (int kk = 0; kk < 2; kk++) begin
            send(kk, 8'h00, 1'b1, 0, 0, 8'h00, da, ps);
            chk($sformatf("b2b_u%0d_first_done", kk), da, 45);
            chk($sformatf("b2b_u%0d_first_parity", kk), ps, (kk == 1) ? 1 : 0);
            send(kk, 8'hFF, 1'b0, 0, 0, 8'h00, da, ps);
            chk($sformatf("b2b_u%0d_second_done", kk), da, 45);
            chk($sformatf("b2b_u%0d_second_parity", kk), ps, (kk == 1) ? 1 : 0);
            idle(kk, 2);
        end

        // Reset during data bit 3 (cycles 17..20), then a clean frame.
        build_expected(0, 8'h0F);
        data[0]  = 8'h0F;
        valid[0] = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk($sformatf("abort_cycle%0d", c), {dout[0], busy[0], done[0], ready[0]},
                {exp_q[c-1], 3'b100});
            valid[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_edge", {dout[0], busy[0], done[0], ready[0]}, 4'b1000);
        rst = 1'b0;
        idle(0, 4);
        send(0, 8'h5A, 1'b0, 0, 0, 8'h00, da, ps);
        chk("after_abort_done", da, 45);
        chk("after_abort_parity", ps, 1'b0);
        idle(0, 1);

        // Random words, random mid-frame data changes and stray valid pulses.
        for (int n = 0; n < 15; n++) begin
            k  = $urandom_range(2, 0);
            d  = 8'($urandom);
            a  = 8'($urandom);
            f  = (1 + 8 + int'(par_en_of(k)) + stops_of(k)) * clks_of(k);
            ch = $urandom_range(f, 2);
            pu = ($urandom_range(1, 0) == 1) ? $urandom_range(f, 2) : 0;
            send(k, d, 1'b0, ch, pu, a, da, ps);
            chk($sformatf("rand%0d_done_cycle", n), da, f + 1);
            idle(k, $urandom_range(2, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
